// File: rtl/vga_timing_gen.sv
// Parametrised VGA timing generator with a latency-matched pixel output stage.
// Optional internal 8-bar test pattern: define VGA_TIMING_TEST_PATTERN_EN.
module vga_timing_gen #(
    parameter int unsigned H_ACT   = 640,
    parameter int unsigned H_FRONT = 16,
    parameter int unsigned H_SYNC  = 96,
    parameter int unsigned H_BACK  = 48,
    parameter int unsigned V_ACT   = 480,
    parameter int unsigned V_FRONT = 10,
    parameter int unsigned V_SYNC  = 2,
    parameter int unsigned V_BACK  = 33,
    parameter int unsigned H_POL   = 0,
    parameter int unsigned V_POL   = 0,
    parameter int unsigned CW      = 11,
    parameter int unsigned PIPE    = 1
) (
    input  logic          clk_pix,
    input  logic          rst_pix,
    input  logic          clk_locked,
`ifdef VGA_TIMING_TEST_PATTERN_EN
    input  logic          pattern_sel,
`endif
    output logic [CW-1:0] sx,
    output logic [CW-1:0] sy,
    output logic          de,
    output logic          line_start,
    output logic          frame_start,
    input  logic [7:0]    pix_r,
    input  logic [7:0]    pix_g,
    input  logic [7:0]    pix_b,
    output logic [7:0]    VGA_R,
    output logic [7:0]    VGA_G,
    output logic [7:0]    VGA_B,
    output logic          VGA_HS,
    output logic          VGA_VS,
    output logic          VGA_BLANK_N,
    output logic          VGA_SYNC_N
);

    localparam int unsigned H_TOTAL = H_ACT + H_FRONT + H_SYNC + H_BACK;
    localparam int unsigned V_TOTAL = V_ACT + V_FRONT + V_SYNC + V_BACK;

    localparam logic [CW-1:0] H_LAST   = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] V_LAST   = CW'(V_TOTAL - 1);
    localparam logic [CW-1:0] H_ACT_C  = CW'(H_ACT);
    localparam logic [CW-1:0] V_ACT_C  = CW'(V_ACT);
    localparam logic [CW-1:0] HS_BEG   = CW'(H_ACT + H_FRONT);
    localparam logic [CW-1:0] HS_END   = CW'(H_ACT + H_FRONT + H_SYNC);
    localparam logic [CW-1:0] VS_BEG   = CW'(V_ACT + V_FRONT);
    localparam logic [CW-1:0] VS_END   = CW'(V_ACT + V_FRONT + V_SYNC);

    localparam logic HS_ON = (H_POL != 0);
    localparam logic VS_ON = (V_POL != 0);

`ifdef VGA_TIMING_TEST_PATTERN_EN
    localparam int unsigned PW = 27;
`else
    localparam int unsigned PW = 3;
`endif

    // Parameter sanity checks at elaboration
    if (((H_TOTAL - 1) >> CW) != 0 || ((V_TOTAL - 1) >> CW) != 0) begin : g_bad_cw
        $error("vga_timing_gen: CW too small for H_TOTAL/V_TOTAL");
    end
    if (PIPE > 4) begin : g_bad_pipe
        $error("vga_timing_gen: PIPE must be 0..4");
    end
    if (H_FRONT == 0 || H_SYNC == 0 || H_BACK == 0 ||
        V_FRONT == 0 || V_SYNC == 0 || V_BACK == 0) begin : g_bad_porch
        $error("vga_timing_gen: porch and sync widths must be non-zero");
    end

    logic          w_rst;
    logic [CW-1:0] r_sx;
    logic [CW-1:0] r_sy;
    logic          r_run;
    logic          r_de;
    logic          r_hs;
    logic          r_vs;
    logic          r_ls;
    logic          r_fs;
    logic [CW-1:0] w_nx;
    logic [CW-1:0] w_ny;

    assign w_rst = rst_pix | ~clk_locked;

    // Next coordinate; the first clock out of reset presents (0,0) rather than advancing
    always_comb begin
        w_nx = '0;
        w_ny = '0;
        if (r_run) begin
            if (r_sx == H_LAST) begin
                w_nx = '0;
                w_ny = (r_sy == V_LAST) ? '0 : r_sy + CW'(1);
            end else begin
                w_nx = r_sx + CW'(1);
                w_ny = r_sy;
            end
        end
    end

    // Counters plus timing flags, all decoded from the next coordinate so they stay aligned
    always_ff @(posedge clk_pix) begin
        if (w_rst) begin
            r_sx  <= '0;
            r_sy  <= '0;
            r_run <= 1'b0;
            r_de  <= 1'b0;
            r_hs  <= 1'b0;
            r_vs  <= 1'b0;
            r_ls  <= 1'b0;
            r_fs  <= 1'b0;
        end else begin
            r_sx  <= w_nx;
            r_sy  <= w_ny;
            r_run <= 1'b1;
            r_de  <= (w_nx < H_ACT_C) && (w_ny < V_ACT_C);
            r_hs  <= (w_nx >= HS_BEG) && (w_nx < HS_END);
            r_vs  <= (w_ny >= VS_BEG) && (w_ny < VS_END);
            r_ls  <= (w_nx == '0);
            r_fs  <= (w_nx == '0) && (w_ny == '0);
        end
    end

    assign sx          = r_sx;
    assign sy          = r_sy;
    assign de          = r_de;
    assign line_start  = r_ls;
    assign frame_start = r_fs;

    logic [PW-1:0] w_raw;
    logic [PW-1:0] w_tap;

`ifdef VGA_TIMING_TEST_PATTERN_EN
    logic [2:0] w_bar;

    function automatic logic [CW-1:0] bar_edge(input int unsigned j);
        return CW'((j * H_ACT + 7) / 8);
    endfunction

    // Bar index floor(sx*8/H_ACT) by threshold compare instead of a divider
    always_comb begin
        w_bar = 3'd0;
        for (int unsigned j = 1; j < 8; j++) begin
            if (r_sx >= bar_edge(j)) begin
                w_bar = 3'(j);
            end
        end
    end

    assign w_raw = {r_de, r_hs, r_vs, {8{w_bar[2]}}, {8{w_bar[1]}}, {8{w_bar[0]}}};
`else
    assign w_raw = {r_de, r_hs, r_vs};
`endif

    // Delay line matching the external pixel source latency
    if (PIPE == 0) begin : g_nopipe
        assign w_tap = w_raw;
    end else begin : g_pipe
        logic [PW-1:0] r_stage [PIPE];

        always_ff @(posedge clk_pix) begin
            if (w_rst) begin
                for (int unsigned i = 0; i < PIPE; i++) begin
                    r_stage[i] <= '0;
                end
            end else begin
                r_stage[0] <= w_raw;
                for (int unsigned i = 1; i < PIPE; i++) begin
                    r_stage[i] <= r_stage[i-1];
                end
            end
        end

        assign w_tap = r_stage[PIPE-1];
    end

    logic       w_de_d;
    logic       w_hs_d;
    logic       w_vs_d;
    logic [7:0] w_src_r;
    logic [7:0] w_src_g;
    logic [7:0] w_src_b;

    assign w_de_d = w_tap[PW-1];
    assign w_hs_d = w_tap[PW-2];
    assign w_vs_d = w_tap[PW-3];

`ifdef VGA_TIMING_TEST_PATTERN_EN
    assign w_src_r = pattern_sel ? w_tap[23:16] : pix_r;
    assign w_src_g = pattern_sel ? w_tap[15:8]  : pix_g;
    assign w_src_b = pattern_sel ? w_tap[7:0]   : pix_b;
`else
    assign w_src_r = pix_r;
    assign w_src_g = pix_g;
    assign w_src_b = pix_b;
`endif

    logic [7:0] r_vga_r;
    logic [7:0] r_vga_g;
    logic [7:0] r_vga_b;
    logic       r_vga_hs;
    logic       r_vga_vs;
    logic       r_vga_blank_n;

    // DAC output register; colour is forced to black outside the active area
    always_ff @(posedge clk_pix) begin
        if (w_rst) begin
            r_vga_r       <= '0;
            r_vga_g       <= '0;
            r_vga_b       <= '0;
            r_vga_hs      <= ~HS_ON;
            r_vga_vs      <= ~VS_ON;
            r_vga_blank_n <= 1'b0;
        end else begin
            r_vga_r       <= w_de_d ? w_src_r : 8'h00;
            r_vga_g       <= w_de_d ? w_src_g : 8'h00;
            r_vga_b       <= w_de_d ? w_src_b : 8'h00;
            r_vga_hs      <= w_hs_d ? HS_ON : ~HS_ON;
            r_vga_vs      <= w_vs_d ? VS_ON : ~VS_ON;
            r_vga_blank_n <= w_de_d;
        end
    end

    assign VGA_R       = r_vga_r;
    assign VGA_G       = r_vga_g;
    assign VGA_B       = r_vga_b;
    assign VGA_HS      = r_vga_hs;
    assign VGA_VS      = r_vga_vs;
    assign VGA_BLANK_N = r_vga_blank_n;
    assign VGA_SYNC_N  = 1'b1;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: a default 640x480 instance and a small active-high-sync PIPE=2 instance.
module tb_vga_timing_gen;

    localparam int A_HA = 640, A_HF = 16, A_HS = 96, A_HB = 48;
    localparam int A_VA = 480, A_VF = 10, A_VS = 2,  A_VB = 33, A_PIPE = 1;
    localparam int B_HA = 40,  B_HF = 4,  B_HS = 6,  B_HB = 5;
    localparam int B_VA = 20,  B_VF = 2,  B_VS = 3,  B_VB = 2,  B_PIPE = 2;
    localparam int B_HT = B_HA + B_HF + B_HS + B_HB;
    localparam int B_VT = B_VA + B_VF + B_VS + B_VB;

    logic        clk;
    logic        a_rst, a_lock, b_rst, b_lock;
    logic [10:0] a_sx, a_sy;
    logic [7:0]  b_sx, b_sy;
    logic        a_de, a_ls, a_fs, b_de, b_ls, b_fs;
    logic [7:0]  a_pr, a_pg, a_pb, b_pr, b_pg, b_pb;
    logic [7:0]  a_vr, a_vg, a_vb, b_vr, b_vg, b_vb;
    logic        a_hs, a_vs, a_bn, a_sn, b_hs, b_vs, b_bn, b_sn;

    int total = 0;
    int bad   = 0;
    int na    = -1;
    int nb    = -1;
    logic [7:0] a_lr, a_lg, a_lb, b_lg, b_lb;
    logic [7:0] b_p1 = 8'h00, b_p2 = 8'h00;

    vga_timing_gen #(
        .H_ACT(A_HA), .H_FRONT(A_HF), .H_SYNC(A_HS), .H_BACK(A_HB),
        .V_ACT(A_VA), .V_FRONT(A_VF), .V_SYNC(A_VS), .V_BACK(A_VB),
        .H_POL(0), .V_POL(0), .CW(11), .PIPE(A_PIPE)
    ) u_a (
        .clk_pix(clk), .rst_pix(a_rst), .clk_locked(a_lock),
`ifdef VGA_TIMING_TEST_PATTERN_EN
        .pattern_sel(1'b0),
`endif
        .sx(a_sx), .sy(a_sy), .de(a_de), .line_start(a_ls), .frame_start(a_fs),
        .pix_r(a_pr), .pix_g(a_pg), .pix_b(a_pb),
        .VGA_R(a_vr), .VGA_G(a_vg), .VGA_B(a_vb),
        .VGA_HS(a_hs), .VGA_VS(a_vs), .VGA_BLANK_N(a_bn), .VGA_SYNC_N(a_sn)
    );

    vga_timing_gen #(
        .H_ACT(B_HA), .H_FRONT(B_HF), .H_SYNC(B_HS), .H_BACK(B_HB),
        .V_ACT(B_VA), .V_FRONT(B_VF), .V_SYNC(B_VS), .V_BACK(B_VB),
        .H_POL(1), .V_POL(1), .CW(8), .PIPE(B_PIPE)
    ) u_b (
        .clk_pix(clk), .rst_pix(b_rst), .clk_locked(b_lock),
`ifdef VGA_TIMING_TEST_PATTERN_EN
        .pattern_sel(1'b0),
`endif
        .sx(b_sx), .sy(b_sy), .de(b_de), .line_start(b_ls), .frame_start(b_fs),
        .pix_r(b_pr), .pix_g(b_pg), .pix_b(b_pb),
        .VGA_R(b_vr), .VGA_G(b_vg), .VGA_B(b_vb),
        .VGA_HS(b_hs), .VGA_VS(b_vs), .VGA_BLANK_N(b_bn), .VGA_SYNC_N(b_sn)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Timing at n clocks after reset release; n<0 means still in reset (all inactive)
    function automatic void model(input int n, input int ha, hf, hs, hb, va, vf, vs, vb,
                                  output int x, output int y, output bit dv, output bit hv, output bit vv);
        int ht, vt;
        ht = ha + hf + hs + hb;
        vt = va + vf + vs + vb;
        if (n < 0) begin
            x = 0; y = 0; dv = 0; hv = 0; vv = 0;
        end else begin
            x  = n % ht;
            y  = (n / ht) % vt;
            dv = (x < ha) && (y < va);
            hv = (x >= ha + hf) && (x < ha + hf + hs);
            vv = (y >= va + vf) && (y < va + vf + vs);
        end
    endfunction

    // Advance one clock; remember what the DUTs sampled, then drive new pixels
    task automatic tick();
        logic ra, rb;
        ra = a_rst | ~a_lock;
        rb = b_rst | ~b_lock;
        a_lr = a_pr; a_lg = a_pg; a_lb = a_pb;
        b_lg = b_pg; b_lb = b_pb;
        @(posedge clk);
        na = ra ? -1 : na + 1;
        nb = rb ? -1 : nb + 1;
        #1;
        a_pr = 8'($urandom); a_pg = 8'($urandom); a_pb = 8'($urandom);
        b_pg = 8'($urandom); b_pb = 8'($urandom);
        b_pr = b_p2;
        b_p2 = b_p1;
        b_p1 = b_sx;
    endtask

    task automatic model_step_a();
        int x, y, dx, dy;
        bit dv, hv, vv, ddv, dhv, dvv;
        model(na, A_HA, A_HF, A_HS, A_HB, A_VA, A_VF, A_VS, A_VB, x, y, dv, hv, vv);
        model(na - A_PIPE - 1, A_HA, A_HF, A_HS, A_HB, A_VA, A_VF, A_VS, A_VB, dx, dy, ddv, dhv, dvv);
        total += 12;
        if (a_sx !== 11'(x)) begin bad++; $display("FAIL a_sx n=%0d got=%0d want=%0d", na, a_sx, x); end
        if (a_sy !== 11'(y)) begin bad++; $display("FAIL a_sy n=%0d got=%0d want=%0d", na, a_sy, y); end
        if (a_de !== dv) begin bad++; $display("FAIL a_de n=%0d got=%b want=%b", na, a_de, dv); end
        if (a_ls !== (na >= 0 && x == 0)) begin bad++; $display("FAIL a_line_start n=%0d got=%b", na, a_ls); end
        if (a_fs !== (na >= 0 && x == 0 && y == 0)) begin bad++; $display("FAIL a_frame_start n=%0d got=%b", na, a_fs); end
        if (a_bn !== ddv) begin bad++; $display("FAIL a_blank_n n=%0d got=%b want=%b", na, a_bn, ddv); end
        if (a_hs !== ~dhv) begin bad++; $display("FAIL a_hs n=%0d got=%b want=%b", na, a_hs, ~dhv); end
        if (a_vs !== ~dvv) begin bad++; $display("FAIL a_vs n=%0d got=%b want=%b", na, a_vs, ~dvv); end
        if (a_vr !== (ddv ? a_lr : 8'h00)) begin bad++; $display("FAIL a_r n=%0d got=%0h want=%0h", na, a_vr, ddv ? a_lr : 8'h00); end
        if (a_vg !== (ddv ? a_lg : 8'h00)) begin bad++; $display("FAIL a_g n=%0d got=%0h want=%0h", na, a_vg, ddv ? a_lg : 8'h00); end
        if (a_vb !== (ddv ? a_lb : 8'h00)) begin bad++; $display("FAIL a_b n=%0d got=%0h want=%0h", na, a_vb, ddv ? a_lb : 8'h00); end
        if (a_sn !== 1'b1) begin bad++; $display("FAIL a_sync_n n=%0d got=%b want=1", na, a_sn); end
    endtask

    task automatic model_step_b();
        int x, y, dx, dy;
        bit dv, hv, vv, ddv, dhv, dvv;
        model(nb, B_HA, B_HF, B_HS, B_HB, B_VA, B_VF, B_VS, B_VB, x, y, dv, hv, vv);
        model(nb - B_PIPE - 1, B_HA, B_HF, B_HS, B_HB, B_VA, B_VF, B_VS, B_VB, dx, dy, ddv, dhv, dvv);
        total += 11;
        if (b_sx !== 8'(x)) begin bad++; $display("FAIL b_sx n=%0d got=%0d want=%0d", nb, b_sx, x); end
        if (b_sy !== 8'(y)) begin bad++; $display("FAIL b_sy n=%0d got=%0d want=%0d", nb, b_sy, y); end
        if (b_de !== dv) begin bad++; $display("FAIL b_de n=%0d got=%b want=%b", nb, b_de, dv); end
        if (b_ls !== (nb >= 0 && x == 0)) begin bad++; $display("FAIL b_line_start n=%0d got=%b", nb, b_ls); end
        if (b_fs !== (nb >= 0 && x == 0 && y == 0)) begin bad++; $display("FAIL b_frame_start n=%0d got=%b", nb, b_fs); end
        if (b_bn !== ddv) begin bad++; $display("FAIL b_blank_n n=%0d got=%b want=%b", nb, b_bn, ddv); end
        if (b_hs !== dhv) begin bad++; $display("FAIL b_hs n=%0d got=%b want=%b", nb, b_hs, dhv); end
        if (b_vs !== dvv) begin bad++; $display("FAIL b_vs n=%0d got=%b want=%b", nb, b_vs, dvv); end
        if (b_vr !== (ddv ? 8'(dx) : 8'h00)) begin bad++; $display("FAIL b_r_column n=%0d got=%0h want=%0h", nb, b_vr, ddv ? 8'(dx) : 8'h00); end
        if (b_vg !== (ddv ? b_lg : 8'h00)) begin bad++; $display("FAIL b_g n=%0d got=%0h want=%0h", nb, b_vg, ddv ? b_lg : 8'h00); end
        if (b_vb !== (ddv ? b_lb : 8'h00)) begin bad++; $display("FAIL b_b n=%0d got=%0h want=%0h", nb, b_vb, ddv ? b_lb : 8'h00); end
    endtask

    task automatic test_reset();
        a_rst = 1'b1; b_rst = 1'b1; a_lock = 1'b1; b_lock = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            total += 4;
            if ({a_hs, a_vs, a_bn} !== 3'b110) begin bad++; $display("FAIL rst_a_sync got=%b want=110", {a_hs, a_vs, a_bn}); end
            if ({a_vr, a_vg, a_vb} !== 24'h0) begin bad++; $display("FAIL rst_a_rgb got=%0h want=0", {a_vr, a_vg, a_vb}); end
            if ({b_hs, b_vs, b_bn} !== 3'b000) begin bad++; $display("FAIL rst_b_sync got=%b want=000", {b_hs, b_vs, b_bn}); end
            if ({a_sx, a_sy, a_de, a_ls, a_fs} !== 25'h0) begin bad++; $display("FAIL rst_a_counters got=%0h want=0", {a_sx, a_sy, a_de, a_ls, a_fs}); end
        end
        a_rst = 1'b0; b_rst = 1'b0;
        tick();
        total += 2;
        if ({a_sx, a_sy, a_de, a_ls, a_fs} !== {11'd0, 11'd0, 3'b111}) begin
            bad++; $display("FAIL first_a got sx=%0d sy=%0d de/ls/fs=%b want 0 0 111", a_sx, a_sy, {a_de, a_ls, a_fs});
        end
        if ({b_sx, b_sy, b_de, b_ls, b_fs} !== {8'd0, 8'd0, 3'b111}) begin
            bad++; $display("FAIL first_b got sx=%0d sy=%0d de/ls/fs=%b want 0 0 111", b_sx, b_sy, {b_de, b_ls, b_fs});
        end
        model_step_a();
        model_step_b();
    endtask

    task automatic test_default_lines();
        int last_ls = -1, hs_len = 0, bn_len = 0;
        logic p_hs = a_hs, p_bn = a_bn;
        for (int i = 0; i < 3 * 800 + 8; i++) begin
            tick();
            model_step_a();
            model_step_b();
            if (a_ls) begin
                if (last_ls >= 0) begin
                    total++;
                    if (na - last_ls != 800) begin bad++; $display("FAIL a_line_period got=%0d want=800", na - last_ls); end
                end
                last_ls = na;
            end
            if (p_hs && !a_hs) begin
                total++;
                if (a_sx !== 11'd658) begin bad++; $display("FAIL a_hs_fall_sx got=%0d want=658", a_sx); end
                hs_len = 0;
            end
            if (!a_hs) hs_len++;
            if (!p_hs && a_hs) begin
                total++;
                if (hs_len != 96) begin bad++; $display("FAIL a_hs_width got=%0d want=96", hs_len); end
            end
            if (!p_bn && a_bn) bn_len = 0;
            if (a_bn) bn_len++;
            if (p_bn && !a_bn) begin
                total++;
                if (bn_len != 640) begin bad++; $display("FAIL a_blank_width got=%0d want=640", bn_len); end
            end
            p_hs = a_hs;
            p_bn = a_bn;
        end
    endtask

    task automatic test_polarity_pipe2();
        int last_fs = -1, hs_len = 0, vs_len = 0;
        bit hs_seen = 0, vs_seen = 0;
        logic p_hs = b_hs, p_vs = b_vs;
        for (int i = 0; i < 2 * B_HT * B_VT + 20; i++) begin
            tick();
            model_step_b();
            if (b_fs) begin
                if (last_fs >= 0) begin
                    total++;
                    if (nb - last_fs != B_HT * B_VT) begin bad++; $display("FAIL b_frame_period got=%0d want=%0d", nb - last_fs, B_HT * B_VT); end
                end
                last_fs = nb;
            end
            if (!p_hs && b_hs) begin hs_seen = 1; hs_len = 0; end
            if (b_hs) hs_len++;
            if (p_hs && !b_hs && hs_seen) begin
                total++;
                if (hs_len != B_HS) begin bad++; $display("FAIL b_hs_width got=%0d want=%0d", hs_len, B_HS); end
            end
            if (!p_vs && b_vs) begin vs_seen = 1; vs_len = 0; end
            if (b_vs) vs_len++;
            if (p_vs && !b_vs && vs_seen) begin
                total++;
                if (vs_len != B_VS * B_HT) begin bad++; $display("FAIL b_vs_width got=%0d want=%0d", vs_len, B_VS * B_HT); end
            end
            p_hs = b_hs;
            p_vs = b_vs;
        end
    endtask

    task automatic test_lock_drop();
        bit found = 0;
        for (int i = 0; i < 2 * B_HT * B_VT && !found; i++) begin
            tick();
            model_step_b();
            if (b_sx == 8'd30 && b_sy == 8'd12) found = 1;
        end
        total++;
        if (!found) begin bad++; $display("FAIL lock_wait got=timeout want=sx30_sy12"); end
        b_lock = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            model_step_b();
            total++;
            if ({b_bn, b_hs, b_vs, b_vr} !== 11'h0) begin bad++; $display("FAIL lock_idle got=%0h want=0", {b_bn, b_hs, b_vs, b_vr}); end
        end
        b_lock = 1'b1;
        tick();
        model_step_b();
        total++;
        if ({b_sx, b_sy, b_fs} !== 17'h1) begin bad++; $display("FAIL lock_restart got sx=%0d sy=%0d fs=%b want 0 0 1", b_sx, b_sy, b_fs); end
        for (int i = 0; i < B_HT * B_VT + 200; i++) begin
            tick();
            model_step_b();
        end
    endtask

    task automatic test_midframe_reset();
        int pre;
        pre = int'($urandom_range(1500, 50));
        for (int i = 0; i < pre; i++) begin
            tick();
            model_step_a();
        end
        a_rst = 1'b1;
        for (int i = 0; i < int'($urandom_range(3, 1)); i++) begin
            tick();
            model_step_a();
        end
        a_rst = 1'b0;
        tick();
        model_step_a();
        total++;
        if ({a_sx, a_sy, a_fs} !== 23'h1) begin bad++; $display("FAIL a_rst_restart got sx=%0d sy=%0d fs=%b want 0 0 1", a_sx, a_sy, a_fs); end
        for (int i = 0; i < 1700; i++) begin
            tick();
            model_step_a();
        end
    endtask

    initial begin
        a_rst = 1'b1; b_rst = 1'b1; a_lock = 1'b1; b_lock = 1'b1;
        a_pr = 8'h00; a_pg = 8'h00; a_pb = 8'h00;
        b_pr = 8'h00; b_pg = 8'h00; b_pb = 8'h00;
        test_reset();
        test_default_lines();
        test_polarity_pipe2();
        test_lock_drop();
        test_midframe_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
